// File: rtl/clock_step_controller.sv
// rtl/clock_step_controller.sv - clock-enable sequencer: run / single-step / instruction-step
// Optional whole-instruction stepping is enabled by defining INSTR_STEP_EN.
module clock_step_controller #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_btn_i,
    input  logic       run_i,
    input  logic [7:0] div_i,
    input  logic       halt_i,
    input  logic       instr_end_i,
    output logic       clk_en_o,
    output logic       running_o,
    output logic       busy_o,
    output logic       halted_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        INSTR  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          btn_meta;
    logic          btn_sync;
    logic          run_meta;
    logic          run_sync;
    logic          db;
    logic          db_prev;
    logic [DW-1:0] db_cnt;
    logic          press;
    logic [7:0]    cnt;
    logic [7:0]    cnt_next;
    logic          en_next;
    logic          tick;

    // Synchronizers and debouncer; db only moves after a full stable window.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            run_meta <= 1'b0;
            run_sync <= 1'b0;
            db       <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_meta <= step_btn_i;
            btn_sync <= btn_meta;
            run_meta <= run_i;
            run_sync <= run_meta;
            db_prev  <= db;
            if (btn_sync == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES)) begin
                db     <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = db & ~db_prev;
    assign tick  = (cnt == div_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            clk_en_o <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            clk_en_o <= en_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (run_sync) begin
                    state_next = RUN;
                end else if (press) begin
`ifdef INSTR_STEP_EN
                    state_next = INSTR;
`else
                    state_next = STEP;
`endif
                end
            end
            RUN: begin
                if (!run_sync) state_next = IDLE;
            end
            STEP: state_next = IDLE;
            INSTR: begin
`ifdef INSTR_STEP_EN
                if (run_sync) begin
                    state_next = RUN;
                end else if (clk_en_o && instr_end_i) begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            HALTED: state_next = run_sync ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
        if (halt_i) state_next = HALTED;
    end

`ifndef INSTR_STEP_EN
    logic unused_instr_end;
    assign unused_instr_end = instr_end_i;
`endif

    // Any state change restarts the divider and suppresses the enable for that cycle.
    always_comb begin
        en_next  = 1'b0;
        cnt_next = cnt;
        if (state_next != state) begin
            cnt_next = '0;
            en_next  = (state == IDLE) && (state_next == STEP);
        end else if (state == RUN || state == INSTR) begin
            if (tick) begin
                en_next  = 1'b1;
                cnt_next = '0;
            end else begin
                cnt_next = cnt + 8'd1;
            end
        end
    end

    assign running_o = (state == RUN);
    assign busy_o    = (state == STEP) || (state == INSTR);
    assign halted_o  = (state == HALTED);

endmodule

// File: tb/tb_clock_step_controller.sv
// tb/tb_clock_step_controller.sv - randomized and directed bench with a behavioural reference model
module tb_clock_step_controller;

    localparam int D = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_INSTR = 3, M_HALTED = 4;
`ifdef INSTR_STEP_EN
    localparam int BURST = 5;
`else
    localparam int BURST = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       step_btn_i;
    logic       run_i;
    logic [7:0] div_i;
    logic       halt_i;
    logic       instr_end_i;
    logic       clk_en_o;
    logic       running_o;
    logic       busy_o;
    logic       halted_o;

    clock_step_controller #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .step_btn_i(step_btn_i), .run_i(run_i), .div_i(div_i),
        .halt_i(halt_i), .instr_end_i(instr_end_i), .clk_en_o(clk_en_o),
        .running_o(running_o), .busy_o(busy_o), .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state
    int m_mode = M_IDLE;
    bit m_en = 0;
    bit btn_hist[2];
    bit run_hist[2];
    bit m_db = 0, m_db_old = 0;
    int m_mismatch = 0;
    int m_since = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic model_edge();
        bit rs, pr, en;
        int nxt;
        if (rst) begin
            m_mode = M_IDLE; m_en = 0; m_db = 0; m_db_old = 0; m_mismatch = 0; m_since = 0;
            btn_hist[0] = 0; btn_hist[1] = 0; run_hist[0] = 0; run_hist[1] = 0;
            return;
        end
        rs = run_hist[1];
        pr = m_db && !m_db_old;
        nxt = m_mode;
        if (halt_i) nxt = M_HALTED;
        else if (m_mode == M_IDLE) nxt = rs ? M_RUN : (pr ? ((BURST > 1) ? M_INSTR : M_STEP) : M_IDLE);
        else if (m_mode == M_RUN) nxt = rs ? M_RUN : M_IDLE;
        else if (m_mode == M_STEP) nxt = M_IDLE;
        else if (m_mode == M_INSTR) nxt = rs ? M_RUN : ((m_en && instr_end_i) ? M_IDLE : M_INSTR);
        else nxt = rs ? M_RUN : M_IDLE;
        en = 0;
        if (nxt != m_mode) begin
            m_since = 0;
            en = (m_mode == M_IDLE && nxt == M_STEP);
        end else if (m_mode == M_RUN || m_mode == M_INSTR) begin
            if ((m_since % 256) == int'(div_i)) begin
                en = 1;
                m_since = 0;
            end else begin
                m_since++;
            end
        end
        m_db_old = m_db;
        if (btn_hist[1] != m_db) begin
            if (m_mismatch == D) begin
                m_db = btn_hist[1];
                m_mismatch = 0;
            end else begin
                m_mismatch++;
            end
        end else begin
            m_mismatch = 0;
        end
        btn_hist[1] = btn_hist[0]; btn_hist[0] = step_btn_i;
        run_hist[1] = run_hist[0]; run_hist[0] = run_i;
        m_mode = nxt;
        m_en = en;
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check("clk_en", clk_en_o, m_en);
        check("running", running_o, m_mode == M_RUN);
        check("busy", busy_o, m_mode == M_STEP || m_mode == M_INSTR);
        check("halted", halted_o, m_mode == M_HALTED);
    endtask

    initial begin
        int n, t, last, first, busy_n, s;
        bit btn_target;
        rst = 1; step_btn_i = 0; run_i = 0; div_i = 0; halt_i = 0; instr_end_i = 0;
        tick_cycle();
        tick_cycle();
        rst = 0;

        // Idle after reset: nothing moves
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick_cycle();
            n += int'(clk_en_o | running_o | busy_o | halted_o);
        end
        check("idle_quiet", n, 0);

        // Bouncy press then hold: one pulse at t+D+3
        for (int i = 0; i < 10; i++) begin
            step_btn_i = ((i / 2) % 2) == 1;
            tick_cycle();
        end
        step_btn_i = 1;
        t = cyc + 1;
        n = 0; last = -1; busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) step_btn_i = 0;
            tick_cycle();
            if (clk_en_o) begin n++; last = cyc; end
            busy_n += int'(busy_o);
        end
        check("bounce_pulses", n, 1);
        check("bounce_pulse_edge", last, t + D + 3);
        check("bounce_busy_cycles", busy_n, 1);

        // Run at div 3
        div_i = 3; run_i = 1;
        n = 0; last = -1;
        for (int i = 0; i < 40; i++) begin
            tick_cycle();
            if (clk_en_o) begin
                if (last >= 0) check("run_gap", cyc - last, 4);
                n++; last = cyc;
            end
        end
        check("run_pulse_count", (n >= 9 && n <= 11), 1);
        check("run_running", running_o, 1);

        // Halt during run; press while halted is ignored
        div_i = 2;
        for (int i = 0; i < 10; i++) tick_cycle();
        halt_i = 1;
        tick_cycle();
        check("halt_no_en", clk_en_o, 0);
        check("halt_flag", halted_o, 1);
        n = 0;
        run_i = 0;
        step_btn_i = 1;
        for (int i = 0; i < 30; i++) begin
            if (i == 12) step_btn_i = 0;
            tick_cycle();
            n += int'(clk_en_o);
        end
        check("halt_press_ignored", n, 0);
        halt_i = 0;
        tick_cycle();
        check("unhalt_flag", halted_o, 0);
        check("unhalt_idle", running_o | busy_o, 0);

        // Burst at div 0, instruction ends on 5th enable
        div_i = 0; step_btn_i = 1;
        n = 0; first = -1; last = -1;
        for (int i = 0; i < 40; i++) begin
            if (i == 15) step_btn_i = 0;
            tick_cycle();
            if (clk_en_o) begin
                n++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            instr_end_i = clk_en_o && (n == 5);
        end
        instr_end_i = 0;
        check("burst_count", n, BURST);
        check("burst_span", last - first + 1, BURST);
        check("burst_idle", busy_o, 0);

`ifdef INSTR_STEP_EN
        // Mode switch mid-burst
        div_i = 2; step_btn_i = 1;
        n = 0;
        for (int i = 0; i < 30 && !clk_en_o; i++) tick_cycle();
        check("switch_first_en", clk_en_o, 1);
        run_i = 1;
        s = cyc + 1;
        tick_cycle();
        tick_cycle();
        check("switch_running_early", running_o, 0);
        tick_cycle();
        check("switch_running_edge", cyc - s, 2);
        check("switch_running", running_o, 1);
        for (int i = 0; i < 12; i++) begin
            tick_cycle();
            n += int'(clk_en_o);
        end
        check("switch_rate", n, 4);
        step_btn_i = 0; run_i = 0;
        for (int i = 0; i < 15; i++) tick_cycle();
`else
        s = 0;
`endif

        // Lowering div below cnt wraps without an enable
        div_i = 200; run_i = 1;
        for (int i = 0; i < 60; i++) tick_cycle();
        div_i = 5;
        n = 0;
        for (int i = 0; i < 150; i++) begin
            tick_cycle();
            n += int'(clk_en_o);
        end
        check("wrap_silent", n, 0);
        n = 0;
        for (int i = 0; i < 70; i++) begin
            tick_cycle();
            n += int'(clk_en_o);
        end
        check("wrap_resumes", n > 0, 1);
        run_i = 0;
        for (int i = 0; i < 5; i++) tick_cycle();

        // Randomized traffic against the model
        btn_target = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) btn_target = ~btn_target;
            step_btn_i = ($urandom_range(0, 5) == 0) ? ~btn_target : btn_target;
            if ($urandom_range(0, 79) == 0) run_i = ~run_i;
            if (halt_i) halt_i = ($urandom_range(0, 7) != 0);
            else halt_i = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) div_i = 8'($urandom_range(0, 4));
            instr_end_i = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_step_controller.md
# clock_step_controller

Clock-enable sequencer for the 8-bit CPU core. It takes the raw manual-step button and run/step switch from the pins and the CPU's halt and instruction-end signals. From these it produces a single-cycle `clk_en_o` that gates every architectural register. It supports free-running at a programmable rate, single-cycle stepping, and (optionally) whole-instruction stepping. Button conditioning is internal: synchronizer, debouncer, and rising-edge detection on the debounced level.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before the debounced button level changes; legal ≥1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `step_btn_i`  in  1  raw manual-step button; asynchronous, bouncy.
- `run_i`  in  1  raw mode switch: 1 = run, 0 = step; asynchronous, not debounced.
- `div_i`  in  8  run-rate divider; enable period is `div_i`+1 cycles; sampled every cycle.
- `halt_i`  in  1  CPU HLT, synchronous to `clk`, level.
- `instr_end_i`  in  1  CPU sequencer flag: the current enable completes the instruction; synchronous.
- `clk_en_o`  out  1  registered one-cycle clock-enable pulse to the CPU.
- `running_o`  out  1  state == RUN.
- `busy_o`  out  1  state == STEP or INSTR.
- `halted_o`  out  1  state == HALTED.

## Operation
- Input conditioning:
  - Two-flop synchronizers on `step_btn_i` and `run_i`.
  - Debounce counter on the synchronized button. The debounced level `db` flips after `DEBOUNCE_CYCLES` consecutive cycles of sync ≠ `db`.
  - Any cycle with sync == `db` clears the counter.
  - `press` = rising edge of `db` (registered `db` vs current `db`). A press is exactly one cycle wide.
- States: IDLE, RUN, STEP, INSTR, HALTED. Priority order within a cycle: `rst` > `halt_i` > mode switch > `press`.
  - Any state, `halt_i`=1 → HALTED. No enable is issued in that cycle.
  - HALTED, `halt_i`=0 → RUN if synced run = 1, else IDLE.
  - IDLE, synced run = 1 → RUN. Divider cleared.
  - IDLE, `press` → STEP, or INSTR when `INSTR_STEP_EN` is defined.
  - STEP → IDLE after exactly one `clk_en_o` pulse.
  - RUN, synced run = 0 → IDLE.
  - INSTR, synced run = 1 → RUN. The burst is aborted.
- Run divider: 8-bit counter `cnt`, cleared on entry to RUN or INSTR. An enable fires when `cnt` == `div_i`, and `cnt` then returns to 0; otherwise `cnt` increments.
  - `div_i`=0 gives an enable every cycle.
  - If `div_i` is lowered below the current `cnt`, `cnt` wraps 255→0 with no enable at the wrap and continues.
- Presses outside IDLE are discarded, not queued.
- `clk_en_o` is never high in two consecutive cycles unless `div_i`=0 in RUN or INSTR.

## Timing
- Reset: state IDLE; `cnt`, synchronizers, `db` and debounce counter = 0.
  - `clk_en_o`, `running_o`, `busy_o`, `halted_o` = 0 in the cycle after the `rst` edge.
  - `rst` mid-burst aborts immediately; no further enables are issued.
- Button latency: a raw rise sampled at edge t, held stable, gives `db`=1 at t+2+D, where D = `DEBOUNCE_CYCLES`. `clk_en_o` is high for the cycle t+D+3 only.
- Release: it follows the same debounce; a release generates no enable.
- Run: the first enable occurs `div_i`+1 cycles after RUN entry, then one every `div_i`+1 cycles.
- `halt_i` rising at edge t: `clk_en_o`=0 from t+1, and `halted_o`=1 from t+1.
- Status outputs are decoded from registered state, with no combinational path from inputs.

## Configuration
- `INSTR_STEP_EN` defined:
  - `press` in IDLE enters INSTR.
  - INSTR issues enables at the run-divider rate.
  - INSTR returns to IDLE after the enable pulse in whose cycle `instr_end_i`=1.
- Not defined:
  - INSTR is unreachable and `instr_end_i` is ignored.
  - Every press produces exactly one enable via STEP.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, then all inputs 0 for 100 cycles → all outputs 0 throughout.
- Bouncy press, `DEBOUNCE_CYCLES`=4, step mode: toggle `step_btn_i` every 2 cycles for 10 cycles, then hold 1 from edge t → exactly one `clk_en_o` pulse at t+7, `busy_o` high for one cycle.
- Run, `div_i`=3: `run_i`=1 for 40 cycles → enables every 4th cycle (10 pulses ±1 for entry latency); `running_o`=1.
- Halt during run: assert `halt_i` at edge t → no `clk_en_o` from t+1, `halted_o`=1. A button press while halted produces no enable. Deassert `halt_i` with `run_i`=0 → IDLE, `halted_o`=0.
- `INSTR_STEP_EN`, `div_i`=0: press; drive `instr_end_i`=1 on the 5th enable → exactly 5 consecutive enables, then IDLE. Repeat without the macro → 1 enable.
- Mode switch mid-burst: set `run_i`=1 during INSTR → `running_o`=1 two cycles later, and enables continue at the `div_i` rate.
